// File: rtl/add_sub_arbiter_if.sv
// Request/operand/result bundle shared by two requesters and the add_sub_arbiter.
// master drives requests and operands; slave (the arbiter) returns grants and results.
interface add_sub_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] x0;
    logic [3:0] y0;
    logic [3:0] x1;
    logic [3:0] y1;
    logic       op0;
    logic       op1;
    logic       gnt0;
    logic       gnt1;
    logic [3:0] res;
    logic       res_cout;
    logic       res_valid;
    logic       res_id;
    logic       busy;

    modport master (
        output req0, req1, x0, y0, x1, y1, op0, op1,
        input  gnt0, gnt1, res, res_cout, res_valid, res_id, busy
    );

    modport slave (
        input  req0, req1, x0, y0, x1, y1, op0, op1,
        output gnt0, gnt1, res, res_cout, res_valid, res_id, busy
    );
endinterface

// File: rtl/add_sub_arbiter.sv
// Two requesters share one 4-bit add_sub unit through an IDLE/EXEC/RESP arbiter.
// Define ADD_SUB_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (requester 0).
module add_sub (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       sub,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] y_eff;
    logic [4:0] sum;

    // Subtract adds the 4-bit two's complement of y, so y=0 yields no carry.
    always_comb begin
        y_eff = sub ? 4'(4'd0 - y) : y;
        sum   = {1'b0, x} + {1'b0, y_eff};
    end

    assign s    = sum[3:0];
    assign cout = sum[4];
endmodule

module add_sub_arbiter (
    input logic               clk,
    input logic               rst,
    add_sub_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opx;
    logic [3:0] opy;
    logic       opsub;
    logic       opid;
    logic [3:0] sum;
    logic       sum_cout;
    logic       take0;
    logic       take1;

`ifdef ADD_SUB_ARB_RR_EN
    logic       last_gnt;
`endif

    add_sub u_add_sub (
        .x    (opx),
        .y    (opy),
        .sub  (opsub),
        .s    (sum),
        .cout (sum_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take0     = 1'b0;
        take1     = 1'b0;
        case (state)
            IDLE: begin
`ifdef ADD_SUB_ARB_RR_EN
                // On a tie, favour whoever was not granted last.
                if (bus.req0 && bus.req1) begin
                    take0 = last_gnt;
                    take1 = !last_gnt;
                end else begin
                    take0 = bus.req0;
                    take1 = bus.req1;
                end
`else
                take0 = bus.req0;
                take1 = bus.req1 && !bus.req0;
`endif
                if (take0 || take1) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.res       <= 4'd0;
            bus.res_cout  <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.busy      <= 1'b0;
            opx           <= 4'd0;
            opy           <= 4'd0;
            opsub         <= 1'b0;
            opid          <= 1'b0;
        end else begin
            bus.gnt0      <= take0;
            bus.gnt1      <= take1;
            bus.busy      <= (state_nxt != IDLE);
            bus.res_valid <= (state == EXEC);
            if (take0) begin
                opx   <= bus.x0;
                opy   <= bus.y0;
                opsub <= bus.op0;
                opid  <= 1'b0;
            end else if (take1) begin
                opx   <= bus.x1;
                opy   <= bus.y1;
                opsub <= bus.op1;
                opid  <= 1'b1;
            end
            // Result registers load only here and hold through RESP and IDLE.
            if (state == EXEC) begin
                bus.res      <= sum;
                bus.res_cout <= sum_cout;
                bus.res_id   <= opid;
            end
        end
    end

`ifdef ADD_SUB_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)        last_gnt <= 1'b1;
        else if (take0) last_gnt <= 1'b0;
        else if (take1) last_gnt <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Scoreboard bench for add_sub_arbiter: stimulus pushes expected results, a monitor pops and compares.
// Reference results come from plain integer arithmetic; arbitration order from the tie-break rule.
module tb_add_sub_arbiter;
    typedef struct packed {
        logic       id;
        logic [3:0] res;
        logic       cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

`ifdef ADD_SUB_ARB_RR_EN
    bit   model_last = 1'b1;
`endif

    logic       prev_g = 1'b0;
    logic [3:0] held_res = 4'd0;
    logic       held_cout = 1'b0;

    add_sub_arbiter_if bus();

    add_sub_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input bit id, input int x, input int y, input bit sub);
        exp_t e;
        int   s;
        e.id = id;
        if (!sub) begin
            s      = x + y;
            e.res  = 4'(s % 16);
            e.cout = (s >= 16);
        end else begin
            s = x - y;
            if (s < 0) s += 16;
            e.res  = 4'(s);
            e.cout = (y != 0) && (x >= y);
        end
        return e;
    endfunction

    function automatic bit pick_first();
`ifdef ADD_SUB_ARB_RR_EN
        return !model_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic note_grant(input bit id);
`ifdef ADD_SUB_ARB_RR_EN
        model_last = id;
`else
        if (id) begin end
`endif
    endtask

    task automatic note_reset();
`ifdef ADD_SUB_ARB_RR_EN
        model_last = 1'b1;
`endif
    endtask

    task automatic drive_req(input bit id, input bit v, input logic [3:0] x, input logic [3:0] y, input bit op);
        if (id) begin
            bus.req1 = v; bus.x1 = x; bus.y1 = y; bus.op1 = op;
        end else begin
            bus.req0 = v; bus.x0 = x; bus.y0 = y; bus.op0 = op;
        end
    endtask

    task automatic set_req(input bit id, input bit v);
        if (id) bus.req1 = v;
        else    bus.req0 = v;
    endtask

    task automatic wait_gnt(input bit id, input int limit, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (id ? bus.gnt1 : bus.gnt0) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check(id ? "gnt1_arrives" : "gnt0_arrives", int'(found), 1);
    endtask

    task automatic do_single(input bit id, input logic [3:0] x, input logic [3:0] y, input bit op);
        int at;
        @(negedge clk);
        drive_req(id, 1'b1, x, y, op);
        sb.push_back(model(id, int'(x), int'(y), op));
        note_grant(id);
        wait_gnt(id, 8, at);
        set_req(id, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_pair(input logic [3:0] xa, input logic [3:0] ya, input bit oa,
                           input logic [3:0] xb, input logic [3:0] yb, input bit ob);
        int at0, at1;
        bit first;
        exp_t e0, e1;
        e0 = model(1'b0, int'(xa), int'(ya), oa);
        e1 = model(1'b1, int'(xb), int'(yb), ob);
        first = pick_first();
        sb.push_back(first ? e1 : e0);
        sb.push_back(first ? e0 : e1);
        note_grant(first);
        note_grant(!first);
        @(negedge clk);
        drive_req(1'b0, 1'b1, xa, ya, oa);
        drive_req(1'b1, 1'b1, xb, yb, ob);
        wait_gnt(first, 8, at0);
        set_req(first, 1'b0);
        wait_gnt(!first, 8, at1);
        check("pair_grant_gap", at1 - at0, 3);
        set_req(!first, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check("reset_outputs",
                      int'({bus.gnt0, bus.gnt1, bus.res, bus.res_cout, bus.res_valid, bus.res_id, bus.busy}), 0);
                prev_g    = 1'b0;
                held_res  = 4'd0;
                held_cout = 1'b0;
            end else begin
                check("one_gnt_max", int'(bus.gnt0 & bus.gnt1), 0);
                check("valid_latency", int'(bus.res_valid), int'(prev_g));
                check("busy", int'(bus.busy), int'(bus.gnt0 | bus.gnt1 | bus.res_valid));
                if (bus.res_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got res=%0d with empty scoreboard", bus.res);
                    end else begin
                        e = sb.pop_front();
                        check("res", int'(bus.res), int'(e.res));
                        check("res_cout", int'(bus.res_cout), int'(e.cout));
                        check("res_id", int'(bus.res_id), int'(e.id));
                        held_res  = e.res;
                        held_cout = e.cout;
                    end
                end else begin
                    check("res_hold", int'(bus.res), int'(held_res));
                    check("cout_hold", int'(bus.res_cout), int'(held_cout));
                end
                prev_g = bus.gnt0 | bus.gnt1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   at0, at1, cnt, last_at;
        bit   ws[4];
        bit   w, seen;
        logic [3:0] cx, cy;
        bit   cop;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.x0 = 4'd0; bus.y0 = 4'd0; bus.op0 = 1'b0;
        bus.x1 = 4'd0; bus.y1 = 4'd0; bus.op1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        note_reset();

        // Directed arithmetic cases, including the carry and y=0 corners.
        do_single(1'b0, 4'd5, 4'd3, 1'b0);
        do_single(1'b1, 4'd3, 4'd5, 1'b1);
        do_single(1'b1, 4'd9, 4'd9, 1'b1);
        do_single(1'b1, 4'd7, 4'd0, 1'b1);
        do_single(1'b0, 4'd15, 4'd1, 1'b0);
        do_single(1'b0, 4'd15, 4'd15, 1'b0);

        // Both requesters held continuously.
        cx = 4'd6; cy = 4'd2; cop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w     = pick_first();
            ws[i] = w;
            note_grant(w);
            sb.push_back(model(w, int'(cx), int'(cy), cop));
        end
        @(negedge clk);
        drive_req(1'b0, 1'b1, cx, cy, cop);
        drive_req(1'b1, 1'b1, cx, cy, cop);
        cnt = 0;
        last_at = -1;
        for (int i = 0; i < 40 && cnt < 4; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                check("hold_winner", int'(bus.gnt1), int'(ws[cnt]));
                if (cnt > 0) check("hold_gap", cyc - last_at, 3);
                last_at = cyc;
                cnt++;
            end
        end
        check("hold_grant_count", cnt, 4);
        set_req(1'b0, 1'b0);
        set_req(1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset while in EXEC drops the operation.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 4'd2, 4'd2, 1'b0);
        wait_gnt(1'b0, 8, at0);
        set_req(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        note_reset();
        repeat (2) @(negedge clk);
        do_single(1'b1, 4'd8, 4'd8, 1'b0);

        // req1 raised in EXEC with stale operands, refreshed before IDLE samples it.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 4'd4, 4'd2, 1'b1);
        sb.push_back(model(1'b0, 4, 2, 1'b1));
        note_grant(1'b0);
        wait_gnt(1'b0, 8, at0);
        set_req(1'b0, 1'b0);
        drive_req(1'b1, 1'b1, 4'd15, 4'd15, 1'b0);
        @(negedge clk);
        seen = bus.gnt1;
        drive_req(1'b1, 1'b1, 4'd6, 4'd9, 1'b0);
        sb.push_back(model(1'b1, 6, 9, 1'b0));
        note_grant(1'b1);
        check("no_gnt1_in_exec", int'(seen), 0);
        wait_gnt(1'b1, 8, at1);
        check("late_req_gap", at1 - at0, 3);
        set_req(1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Random mix of single and simultaneous requests.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0, 1: do_single(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                default: do_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            endcase
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits, matching the internal add_sub instance.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1 each  operation request from requester 0 / 1.
REQ-005 x0, y0 / x1, y1  input  4 each  operands of requester 0 / 1; held stable while the matching req is high.
REQ-006 op0 / op1  input  1 each  operation select: 0 = x+y, 1 = x-y.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands were captured on the edge that raised it.
REQ-008 res  output  4  result of the granted operation.
REQ-009 res_cout  output  1  carry-out of the granted operation.
REQ-010 res_valid  output  1  one-cycle pulse qualifying res, res_cout and res_id.
REQ-011 res_id  output  1  requester that owns the current result.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 The block SHALL contain exactly one add_sub instance, shared by both requesters, fed only from internal operand registers (opx, opy, opsub, opid).
REQ-014 FSM states SHALL be IDLE, EXEC and RESP; all outputs SHALL be registered.
REQ-015 IDLE: at an edge with req0 or req1 high, select the winner, load opx/opy/opsub/opid from its inputs, set that gnt high for one cycle, and go to EXEC; with no request, stay in IDLE.
REQ-016 EXEC: at the next edge, load res/res_cout from add_sub, set res_id=opid and res_valid=1, clear gnt, and go to RESP.
REQ-017 RESP: at the next edge, clear res_valid and go to IDLE; res and res_cout SHALL hold their values until the next load.
REQ-018 Latency SHALL be fixed: grant at edge k, res_valid high between edges k+1 and k+2, earliest next grant at edge k+3.
REQ-019 Requests SHALL be ignored in EXEC and RESP; a req still high when IDLE samples it SHALL be treated as a new request.
REQ-020 Add: {res_cout,res} SHALL equal x+y modulo 32.
REQ-021 Subtract: res SHALL equal (x-y) mod 16; res_cout SHALL be 1 iff y!=0 and x>=y (y=0 gives res=x, res_cout=0).
REQ-022 Only the winner's operands SHALL be captured; the loser's req SHALL stay pending, with no gnt.
REQ-023 At most one gnt SHALL be high in any cycle.

Reset
REQ-024 With rst high at an edge: state=IDLE, gnt0=gnt1=0, res=0, res_cout=0, res_valid=0, res_id=0, busy=0, operand registers=0, last-grant pointer=1.
REQ-025 Reset SHALL override all other activity; an operation in EXEC or RESP SHALL be dropped without a res_valid pulse.

Configuration
REQ-026 Macro ADD_SUB_ARB_RR_EN defined: round-robin; when both request, grant the requester other than the last granted; the last-grant pointer updates on every grant.
REQ-027 Macro ADD_SUB_ARB_RR_EN undefined: fixed priority; requester 0 always wins ties and the pointer logic is absent.

Verification
REQ-028 Reset, then req0=1, x0=5, y0=3, op0=0 -> gnt0 pulse at edge k; res=8, res_cout=0, res_valid=1, res_id=0 at edge k+1; busy high for 2 cycles.
REQ-029 req1=1, x1=3, y1=5, op1=1 -> res=14, res_cout=0, res_id=1; then x1=9, y1=9, op1=1 -> res=0, res_cout=1; then x1=7, y1=0, op1=1 -> res=7, res_cout=0.
REQ-030 req0=1, x0=15, y0=1, op0=0 -> res=0, res_cout=1.
REQ-031 req0 and req1 held high continuously -> with RR_EN, grants alternate gnt0, gnt1, gnt0 ... every 3 cycles; without RR_EN, only gnt0 is granted.
REQ-032 rst asserted on the edge after a grant (EXEC) -> no res_valid pulse, all outputs 0, next request granted normally.
REQ-033 req1 raised while in EXEC and held -> not granted until IDLE samples it (edge k+3); its operands, not those from edge k+1, are used.
